// File: rtl/ifu_pkg.sv
// ============================================================================
// ifu_pkg : shared widths, constants, state type and PC legality check for the
//           instruction fetch unit.  Rev 1.0
// ============================================================================
`default_nettype none

package ifu_pkg;

  localparam int                ADDR_W    = 8;
  localparam int                INST_W    = 32;
  localparam int unsigned       MEM_BYTES = 128;
  localparam logic [ADDR_W-1:0] RESET_PC  = 8'h00;
  localparam logic [INST_W-1:0] NOP_INST  = 32'h0;

  typedef enum logic {IFU_RUN, IFU_HALT} ifu_state_t;

  // A PC is fetchable when word aligned and a whole word fits below mem_bytes.
  function automatic logic is_legal_pc(input logic [ADDR_W-1:0] pc,
                                       input int unsigned       mem_bytes);
    return (pc[1:0] == 2'b00) && (32'(pc) <= mem_bytes - 32'd4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_pipe_reg.sv
// ============================================================================
// ifid_pipe_reg : IF/ID pipeline register; bubble beats hold beats load.
//                 Rev 1.0
// ============================================================================
`default_nettype none

module ifid_pipe_reg
  import ifu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble_i,
  input  logic              hold_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic              valid_o
);

  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;

  // A bubble leaves pc4 untouched; only inst/valid describe the empty slot.
  always_comb begin
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      inst_d  = inst_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC, next-PC selection, fault halt and IF/ID capture.
//                    Optional macro IFU_PERF_COUNT_EN adds fetch/bubble counters.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned                  MEM_BYTES = ifu_pkg::MEM_BYTES,
  parameter logic [ifu_pkg::ADDR_W-1:0]   RESET_PC  = ifu_pkg::RESET_PC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          branch_taken,
  input  logic [ifu_pkg::ADDR_W-1:0]    branch_target,
  input  logic                          jump,
  input  logic [ifu_pkg::ADDR_W-1:0]    jump_target,
  output logic [ifu_pkg::ADDR_W-1:0]    instAddr,
  input  logic [ifu_pkg::INST_W-1:0]    instruction,
  output logic [ifu_pkg::INST_W-1:0]    ifid_inst,
  output logic [ifu_pkg::ADDR_W-1:0]    ifid_pc4,
  output logic                          ifid_valid,
`ifdef IFU_PERF_COUNT_EN
  output logic [15:0]                   fetch_count,
  output logic [15:0]                   bubble_count,
`endif
  output logic                          fetch_fault
);

  import ifu_pkg::*;

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;
  logic              ifid_bubble;
  logic              ifid_hold;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // The IF/ID action is decided before the legality check so the current
  // word (or bubble) is still taken on the edge that faults.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    next_pc     = pc_q;
    ifid_bubble = 1'b0;
    ifid_hold   = 1'b0;
    case (state_q)
      IFU_RUN: begin
        if (jump || branch_taken) begin
          next_pc     = jump ? jump_target : branch_target;
          ifid_bubble = 1'b1;
        end else if (flush) begin
          next_pc     = pc_plus4;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          ifid_hold   = 1'b1;
        end else begin
          next_pc     = pc_plus4;
        end
        if (is_legal_pc(next_pc, MEM_BYTES)) begin
          pc_d = next_pc;
        end else begin
          state_d = IFU_HALT;
        end
      end
      IFU_HALT: begin
        ifid_bubble = 1'b1;
      end
      default: begin
        state_d = IFU_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IFU_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifid_pipe_reg u_ifid (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (ifid_bubble),
    .hold_i   (ifid_hold),
    .inst_i   (instruction),
    .pc4_i    (pc_plus4),
    .inst_o   (ifid_inst),
    .pc4_o    (ifid_pc4),
    .valid_o  (ifid_valid)
  );

  assign instAddr    = pc_q;
  assign fetch_fault = (state_q == IFU_HALT);

`ifdef IFU_PERF_COUNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] bubble_cnt_q;
  logic        run_fetch;
  logic        run_bubble;

  assign run_fetch  = (state_q == IFU_RUN) && !ifid_bubble && !ifid_hold;
  assign run_bubble = (state_q == IFU_RUN) && (ifid_bubble || ifid_hold);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (run_fetch && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (run_bubble && (bubble_cnt_q != 16'hFFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : self-checking bench for instr_fetch_unit with a
//                       behavioural fetch model and byte-array memory. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  localparam int TB_MEM = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, branch_taken, jump;
  logic [7:0]  branch_target, jump_target, instAddr, ifid_pc4;
  logic [31:0] instruction, ifid_inst;
  logic        ifid_valid, fetch_fault;

  logic        reset_w;
  logic [7:0]  addr_w, pc4_w;
  logic [31:0] instr_w, ifid_inst_w;
  logic        valid_w, fault_w;

`ifdef IFU_PERF_COUNT_EN
  logic [15:0] fetch_count, bubble_count, fc_w, bc_w;
`endif

  logic [7:0] mem [0:255];

  assign instruction = {mem[instAddr], mem[instAddr + 8'd1], mem[instAddr + 8'd2], mem[instAddr + 8'd3]};
  assign instr_w     = {mem[addr_w], mem[addr_w + 8'd1], mem[addr_w + 8'd2], mem[addr_w + 8'd3]};

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instAddr(instAddr),
    .instruction(instruction), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid),
`ifdef IFU_PERF_COUNT_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.MEM_BYTES(256)) dut256 (
    .clk(clk), .reset(reset_w), .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(8'h00),
    .jump(1'b0), .jump_target(8'h00), .instAddr(addr_w),
    .instruction(instr_w), .ifid_inst(ifid_inst_w), .ifid_pc4(pc4_w),
    .ifid_valid(valid_w),
`ifdef IFU_PERF_COUNT_EN
    .fetch_count(fc_w), .bubble_count(bc_w),
`endif
    .fetch_fault(fault_w)
  );

  int nc = 0;
  int nf = 0;

  // Behavioural model state
  logic [7:0]  m_pc, m_pc4;
  logic [31:0] m_inst;
  bit          m_valid, m_halt;
  int          m_fc, m_bc;

  function automatic logic [31:0] word_at(input int a);
    return {mem[a % 256], mem[(a + 1) % 256], mem[(a + 2) % 256], mem[(a + 3) % 256]};
  endfunction

  task automatic model_edge(input bit rst, input bit st, input bit fl, input bit br,
                            input logic [7:0] bt, input bit jp, input logic [7:0] jt);
    int nxt;
    if (rst) begin
      m_pc = 8'h00; m_pc4 = 8'h00; m_inst = 32'h0; m_valid = 0; m_halt = 0;
      m_fc = 0; m_bc = 0;
      return;
    end
    if (m_halt) begin
      m_valid = 0; m_inst = 32'h0;
      return;
    end
    if (jp || br) begin
      nxt = jp ? int'(jt) : int'(bt);
      m_valid = 0; m_inst = 32'h0;
      m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
    end else if (fl) begin
      nxt = (int'(m_pc) + 4) % 256;
      m_valid = 0; m_inst = 32'h0;
      m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
    end else if (st) begin
      nxt = int'(m_pc);
      m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
    end else begin
      nxt = (int'(m_pc) + 4) % 256;
      m_inst = word_at(int'(m_pc)); m_pc4 = 8'(nxt); m_valid = 1;
      m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
    end
    if ((nxt % 4 != 0) || (nxt > TB_MEM - 4)) m_halt = 1;
    else m_pc = 8'(nxt);
  endtask

  task automatic cycle(input bit rst, input bit st, input bit fl, input bit br,
                       input logic [7:0] bt, input bit jp, input logic [7:0] jt);
    reset = rst; stall = st; flush = fl; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    model_edge(rst, st, fl, br, bt, jp, jt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 8'h00, 0, 8'h00);
    cycle(1, 1, 1, 1, 8'h40, 1, 8'h20);
    nc++; if (instAddr !== 8'h00) begin nf++; $display("FAIL reset_pc got %h want 00", instAddr); end
    nc++; if (ifid_valid !== 1'b0) begin nf++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
    nc++; if (ifid_inst !== 32'h0) begin nf++; $display("FAIL reset_inst got %h want 0", ifid_inst); end
    nc++; if (ifid_pc4 !== 8'h00) begin nf++; $display("FAIL reset_pc4 got %h want 00", ifid_pc4); end
    nc++; if (fetch_fault !== 1'b0) begin nf++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      seq(1);
      nc++; if (instAddr !== 8'(4 * k)) begin nf++; $display("FAIL seq_pc k%0d got %0d want %0d", k, instAddr, 4 * k); end
      nc++; if (ifid_pc4 !== 8'(4 * k)) begin nf++; $display("FAIL seq_pc4 k%0d got %0d want %0d", k, ifid_pc4, 4 * k); end
      nc++; if (ifid_valid !== 1'b1) begin nf++; $display("FAIL seq_valid k%0d got %b want 1", k, ifid_valid); end
      nc++; if (ifid_inst !== word_at(4 * (k - 1))) begin nf++; $display("FAIL seq_inst k%0d got %h want %h", k, ifid_inst, word_at(4 * (k - 1))); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    seq(2);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 8'h00, 0, 8'h00);
      nc++; if (instAddr !== 8'd8) begin nf++; $display("FAIL stall_pc got %0d want 8", instAddr); end
      nc++; if (ifid_inst !== word_at(4) || ifid_pc4 !== 8'd8 || ifid_valid !== 1'b1) begin
        nf++; $display("FAIL stall_ifid got %h/%0d/%b want %h/8/1", ifid_inst, ifid_pc4, ifid_valid, word_at(4));
      end
    end
    seq(1);
    nc++; if (instAddr !== 8'd12) begin nf++; $display("FAIL stall_release_pc got %0d want 12", instAddr); end
    nc++; if (ifid_inst !== word_at(8)) begin nf++; $display("FAIL stall_release_inst got %h want %h", ifid_inst, word_at(8)); end
  endtask

  task automatic test_redirect();
    do_reset();
    seq(4);
    cycle(0, 1, 0, 1, 8'h40, 1, 8'h20);
    nc++; if (instAddr !== 8'h20) begin nf++; $display("FAIL redir_pc got %h want 20", instAddr); end
    nc++; if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0) begin nf++; $display("FAIL redir_bubble got %b/%h want 0/0", ifid_valid, ifid_inst); end
    seq(1);
    nc++; if (ifid_inst !== word_at(32) || ifid_valid !== 1'b1 || ifid_pc4 !== 8'h24) begin
      nf++; $display("FAIL redir_capture got %h/%b/%h want %h/1/24", ifid_inst, ifid_valid, ifid_pc4, word_at(32));
    end
    cycle(0, 0, 1, 1, 8'h30, 0, 8'h00);
    nc++; if (instAddr !== 8'h30) begin nf++; $display("FAIL branch_pc got %h want 30", instAddr); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    seq(1);
    cycle(0, 1, 1, 0, 8'h00, 0, 8'h00);
    nc++; if (instAddr !== 8'd8) begin nf++; $display("FAIL flush_pc got %0d want 8", instAddr); end
    nc++; if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0) begin nf++; $display("FAIL flush_bubble got %b/%h want 0/0", ifid_valid, ifid_inst); end
  endtask

  task automatic test_fault();
    do_reset();
    seq(1);
    cycle(0, 0, 0, 1, 8'h42, 0, 8'h00);
    nc++; if (fetch_fault !== 1'b1) begin nf++; $display("FAIL fault_set got %b want 1", fetch_fault); end
    nc++; if (instAddr !== 8'd4 || ifid_valid !== 1'b0) begin nf++; $display("FAIL fault_state got %0d/%b want 4/0", instAddr, ifid_valid); end
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 8'h10, 1'($urandom), 8'h20);
      nc++; if (instAddr !== 8'd4 || ifid_valid !== 1'b0 || fetch_fault !== 1'b1) begin
        nf++; $display("FAIL halt_hold got %0d/%b/%b want 4/0/1", instAddr, ifid_valid, fetch_fault);
      end
    end
    do_reset();
    nc++; if (instAddr !== 8'd0 || fetch_fault !== 1'b0) begin nf++; $display("FAIL fault_clear got %0d/%b want 0/0", instAddr, fetch_fault); end
  endtask

  task automatic test_end_of_mem();
    do_reset();
    seq(31);
    nc++; if (instAddr !== 8'd124) begin nf++; $display("FAIL eom_pc got %0d want 124", instAddr); end
    seq(1);
    nc++; if (fetch_fault !== 1'b1 || instAddr !== 8'd124) begin nf++; $display("FAIL eom_fault got %b/%0d want 1/124", fetch_fault, instAddr); end
    nc++; if (ifid_valid !== 1'b1 || ifid_inst !== word_at(124) || ifid_pc4 !== 8'd128) begin
      nf++; $display("FAIL eom_capture got %b/%h/%0d want 1/%h/128", ifid_valid, ifid_inst, ifid_pc4, word_at(124));
    end
    seq(1);
    nc++; if (ifid_valid !== 1'b0) begin nf++; $display("FAIL eom_halt_valid got %b want 0", ifid_valid); end
  endtask

  task automatic test_wrap256();
    reset_w = 1'b1;
    seq(1);
    reset_w = 1'b0;
    seq(63);
    nc++; if (addr_w !== 8'd252 || fault_w !== 1'b0) begin nf++; $display("FAIL wrap_pre got %0d/%b want 252/0", addr_w, fault_w); end
    seq(1);
    nc++; if (addr_w !== 8'd0 || fault_w !== 1'b0) begin nf++; $display("FAIL wrap_pc got %0d/%b want 0/0", addr_w, fault_w); end
    nc++; if (ifid_inst_w !== word_at(252) || pc4_w !== 8'd0 || valid_w !== 1'b1) begin
      nf++; $display("FAIL wrap_capture got %h/%0d/%b want %h/0/1", ifid_inst_w, pc4_w, valid_w, word_at(252));
    end
    seq(1);
    nc++; if (ifid_inst_w !== word_at(0) || fault_w !== 1'b0) begin nf++; $display("FAIL wrap_next got %h/%b want %h/0", ifid_inst_w, fault_w, word_at(0)); end
  endtask

`ifdef IFU_PERF_COUNT_EN
  task automatic test_perf();
    do_reset();
    seq(5);
    cycle(0, 1, 0, 0, 8'h00, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h00, 0, 8'h00);
    cycle(0, 0, 0, 1, 8'h10, 0, 8'h00);
    seq(5);
    nc++; if (fetch_count !== 16'd10 || bubble_count !== 16'd3) begin
      nf++; $display("FAIL perf_counts got %0d/%0d want 10/3", fetch_count, bubble_count);
    end
    do_reset();
    seq(5);
    nc++; if (fetch_count !== 16'd5) begin nf++; $display("FAIL perf_five got %0d want 5", fetch_count); end
    do_reset();
    nc++; if (fetch_count !== 16'd0 || bubble_count !== 16'd0) begin
      nf++; $display("FAIL perf_reset got %0d/%0d want 0/0", fetch_count, bubble_count);
    end
  endtask
`endif

  task automatic test_random();
    bit rst, st, fl, br, jp;
    logic [7:0] bt, jt;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 7) == 0);
      jp  = ($urandom_range(0, 9) == 0);
      bt  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31) * 4);
      jt  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31) * 4);
      cycle(rst, st, fl, br, bt, jp, jt);
      nc++; if (instAddr !== m_pc) begin nf++; $display("FAIL rnd_pc i%0d got %h want %h", i, instAddr, m_pc); end
      nc++; if (ifid_valid !== m_valid) begin nf++; $display("FAIL rnd_valid i%0d got %b want %b", i, ifid_valid, m_valid); end
      nc++; if (ifid_inst !== m_inst) begin nf++; $display("FAIL rnd_inst i%0d got %h want %h", i, ifid_inst, m_inst); end
      nc++; if (fetch_fault !== m_halt) begin nf++; $display("FAIL rnd_fault i%0d got %b want %b", i, fetch_fault, m_halt); end
      if (m_valid) begin
        nc++; if (ifid_pc4 !== m_pc4) begin nf++; $display("FAIL rnd_pc4 i%0d got %h want %h", i, ifid_pc4, m_pc4); end
      end
`ifdef IFU_PERF_COUNT_EN
      nc++; if (int'(fetch_count) != m_fc || int'(bubble_count) != m_bc) begin
        nf++; $display("FAIL rnd_perf i%0d got %0d/%0d want %0d/%0d", i, fetch_count, bubble_count, m_fc, m_bc);
      end
`endif
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = (a < 16) ? 8'(a) : 8'($urandom_range(0, 255));
    reset = 1'b1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 8'h00; jump_target = 8'h00; reset_w = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_fault();
    test_end_of_mem();
    test_wrap256();
`ifdef IFU_PERF_COUNT_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule

`default_nettype wire
